// File: rtl/cardinal_pkg.sv
// Purpose: shared field layout, port indices and encodings for the cardinal ring router.
// Latency: none (declarations only).
// Backpressure: n/a.
// Packets are numbered big-endian [0:DATA_W-1], so bit 0 is the MSB of the word.
package cardinal_pkg;

    localparam int PKT_W   = 64;

    // Field positions within a packet
    localparam int VC_BIT  = 0;
    localparam int DIR_BIT = 1;
    localparam int HOP_HI  = 8;
    localparam int HOP_LO  = 15;
    localparam int HOP_W   = HOP_LO - HOP_HI + 1;

    // Direction bit encodings
    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    // Port indices used for the per-port arrays inside the router
    localparam int P_CW   = 0;
    localparam int P_CCW  = 1;
    localparam int P_PE   = 2;
    localparam int N_PORT = 3;

    typedef logic [0:PKT_W-1] pkt_t;

endpackage

// File: rtl/cardinal_ring_router_if.sv
// Purpose: bundles the three link-port handshakes (cw, ccw, PE) plus the polarity broadcast.
// Latency: none (wiring only).
// Backpressure: xro/xri are the ready halves of each xsi/xso valid pair.
// Ports: polarity; per port x in {cw,ccw,pe}: xsi/xdi/xro (upstream side), xso/xdo/xri (downstream side).
interface cardinal_ring_router_if #(
    parameter int DATA_W = 64
);
    logic              polarity;

    logic              cwsi, ccwsi, pesi;
    logic [0:DATA_W-1] cwdi, ccwdi, pedi;
    logic              cwro, ccwro, pero;

    logic              cwso, ccwso, peso;
    logic [0:DATA_W-1] cwdo, ccwdo, pedo;
    logic              cwri, ccwri, peri;

    // Router side
    modport slave (
        output polarity,
        input  cwsi, ccwsi, pesi,
        input  cwdi, ccwdi, pedi,
        output cwro, ccwro, pero,
        output cwso, ccwso, peso,
        output cwdo, ccwdo, pedo,
        input  cwri, ccwri, peri
    );

    // NIC / neighbour side
    modport master (
        input  polarity,
        output cwsi, ccwsi, pesi,
        output cwdi, ccwdi, pedi,
        input  cwro, ccwro, pero,
        input  cwso, ccwso, peso,
        input  cwdo, ccwdo, pedo,
        output cwri, ccwri, peri
    );

endinterface

// File: rtl/cardinal_vc_buf.sv
// Purpose: two-VC buffer, one entry per VC, written and cleared by VC index.
// Latency: write visible on full/dat the cycle after the edge.
// Backpressure: caller must only write an empty VC; full[] is the status it checks.
// Ports: clk, reset (async active-low), wr_en/wr_vc/wr_dat, clr_en/clr_vc, full[1:0], dat[1:0].
module cardinal_vc_buf #(
    parameter int DATA_W = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic                        wr_vc,
    input  logic [0:DATA_W-1]           wr_dat,
    input  logic                        clr_en,
    input  logic                        clr_vc,
    output logic [1:0]                  full,
    output logic [1:0][0:DATA_W-1]      dat
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= '0;
            dat  <= '0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                // The router never writes and clears the same VC in one cycle,
                // so the ordering of these two branches is not observable.
                if (wr_en && (int'(wr_vc) == v)) begin
                    full[v] <= 1'b1;
                    dat[v]  <= wr_dat;
                end else if (clr_en && (int'(clr_vc) == v)) begin
                    full[v] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/cardinal_ring_router.sv
// Purpose: one bidirectional ring node (cw, ccw, PE ports) with 2-VC input/output buffers and RR arbitration.
// Latency: 2 cycles from input-link edge to output-link valid when idle; one hop per two cycles.
// Backpressure: xro = input VC[p] empty; a full output VC holds its packet until xri, stalling moves into it.
// Ports: clk, reset (async active-low), rif (slave modport: polarity plus cw/ccw/pe si/di/ro/so/do/ri).
module cardinal_ring_router
    import cardinal_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter bit RR_INIT = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    cardinal_ring_router_if.slave  rif
);

    // Polarity p selects the VC on the links; the opposite VC q moves internally.
    logic pol;
    logic q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pol <= 1'b0;
        else        pol <= ~pol;
    end

    assign q            = ~pol;
    assign rif.polarity = pol;

    // Port-indexed views of the interface
    logic [N_PORT-1:0]              si, ri, ro, so;
    logic [N_PORT-1:0][0:DATA_W-1]  di, dout;

    assign si = {rif.pesi, rif.ccwsi, rif.cwsi};
    assign ri = {rif.peri, rif.ccwri, rif.cwri};
    assign di = {rif.pedi, rif.ccwdi, rif.cwdi};

    assign rif.cwro  = ro[P_CW];
    assign rif.ccwro = ro[P_CCW];
    assign rif.pero  = ro[P_PE];
    assign rif.cwso  = so[P_CW];
    assign rif.ccwso = so[P_CCW];
    assign rif.peso  = so[P_PE];
    assign rif.cwdo  = dout[P_CW];
    assign rif.ccwdo = dout[P_CCW];
    assign rif.pedo  = dout[P_PE];

    logic [1:0]                 ib_full [N_PORT];
    logic [1:0][0:DATA_W-1]     ib_dat  [N_PORT];
    logic [1:0]                 ob_full [N_PORT];
    logic [1:0][0:DATA_W-1]     ob_dat  [N_PORT];

    logic [N_PORT-1:0]              ib_clr;
    logic [N_PORT-1:0]              ob_wr;
    logic [N_PORT-1:0][0:DATA_W-1]  ob_wdat;

    // Head of each input's internal-phase VC, and the same packet with hop-1
    logic [N_PORT-1:0]              in_vld;
    logic [N_PORT-1:0]              hop_zero;
    logic [N_PORT-1:0][0:DATA_W-1]  in_pkt;
    logic [N_PORT-1:0][0:DATA_W-1]  fwd_pkt;

    for (genvar g = 0; g < N_PORT; g++) begin : g_port
        cardinal_vc_buf #(.DATA_W(DATA_W)) u_ib (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (si[g] & ro[g]),
            .wr_vc  (pol),
            .wr_dat (di[g]),
            .clr_en (ib_clr[g]),
            .clr_vc (q),
            .full   (ib_full[g]),
            .dat    (ib_dat[g])
        );

        cardinal_vc_buf #(.DATA_W(DATA_W)) u_ob (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (ob_wr[g]),
            .wr_vc  (q),
            .wr_dat (ob_wdat[g]),
            .clr_en (so[g] & ri[g]),
            .clr_vc (pol),
            .full   (ob_full[g]),
            .dat    (ob_dat[g])
        );

        assign ro[g]   = ~ib_full[g][pol];
        assign so[g]   = ob_full[g][pol];
        assign dout[g] = so[g] ? ob_dat[g][pol] : '0;

        assign in_vld[g]   = ib_full[g][q];
        assign in_pkt[g]   = ib_dat[g][q];
        assign hop_zero[g] = (in_pkt[g][HOP_HI:HOP_LO] == '0);
        assign fwd_pkt[g]  = {in_pkt[g][0:HOP_HI-1],
                              in_pkt[g][HOP_HI:HOP_LO] - HOP_W'(1),
                              in_pkt[g][HOP_LO+1:DATA_W-1]};
    end

    // Two requesters per output. Slot 0 is the ring-side input (cw for the PE
    // output), slot 1 the other; an RR pointer value of 0 favours slot 0.
    logic [N_PORT-1:0]              req0, req1, gnt0, gnt1, space;
    logic [N_PORT-1:0][0:DATA_W-1]  cand0, cand1;
    logic                           pe_fwd;
    logic                           pe_dir;

    assign pe_fwd = in_vld[P_PE] & ~hop_zero[P_PE];
    assign pe_dir = in_pkt[P_PE][DIR_BIT];

    assign req0[P_PE]   = in_vld[P_CW] & hop_zero[P_CW];
    assign cand0[P_PE]  = in_pkt[P_CW];
    assign req1[P_PE]   = in_vld[P_CCW] & hop_zero[P_CCW];
    assign cand1[P_PE]  = in_pkt[P_CCW];

    assign req0[P_CW]   = in_vld[P_CW] & ~hop_zero[P_CW];
    assign cand0[P_CW]  = fwd_pkt[P_CW];
    assign req1[P_CW]   = pe_fwd & (pe_dir == DIR_CW);
    assign cand1[P_CW]  = fwd_pkt[P_PE];

    assign req0[P_CCW]  = in_vld[P_CCW] & ~hop_zero[P_CCW];
    assign cand0[P_CCW] = fwd_pkt[P_CCW];
    assign req1[P_CCW]  = pe_fwd & (pe_dir == DIR_CCW);
    assign cand1[P_CCW] = fwd_pkt[P_PE];

    logic [1:0] rr [N_PORT];

    for (genvar o = 0; o < N_PORT; o++) begin : g_arb
        assign space[o]   = ~ob_full[o][q];
        assign gnt0[o]    = space[o] & req0[o] & (~req1[o] | ~rr[o][q]);
        assign gnt1[o]    = space[o] & req1[o] & (~req0[o] |  rr[o][q]);
        assign ob_wr[o]   = gnt0[o] | gnt1[o];
        assign ob_wdat[o] = gnt1[o] ? cand1[o] : cand0[o];
    end

    // Pointer moves to the loser only on a contested grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int o = 0; o < N_PORT; o++) rr[o] <= {2{RR_INIT}};
        end else begin
            for (int o = 0; o < N_PORT; o++) begin
                if (space[o] && req0[o] && req1[o]) rr[o][q] <= gnt0[o];
            end
        end
    end

    // An input frees when its single request is granted; a hop-0 PE packet
    // is illegal and is dropped without requesting anything.
    assign ib_clr[P_CW]  = hop_zero[P_CW]  ? gnt0[P_PE] : gnt0[P_CW];
    assign ib_clr[P_CCW] = hop_zero[P_CCW] ? gnt1[P_PE] : gnt0[P_CCW];
    assign ib_clr[P_PE]  = (in_vld[P_PE] & hop_zero[P_PE]) | gnt1[P_CW] | gnt1[P_CCW];

endmodule

// File: tb/tb_cardinal_ring_router.sv
module tb_cardinal_ring_router;

    localparam int CW  = 0;
    localparam int CCW = 1;
    localparam int PE  = 2;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cardinal_ring_router_if #(.DATA_W(64)) rif ();

    cardinal_ring_router #(.DATA_W(64), .RR_INIT(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .rif   (rif)
    );

    // Stimulus arrays, port-indexed
    bit          si [3];
    logic [63:0] di [3];
    bit          ri [3];

    assign rif.cwsi  = si[CW];
    assign rif.ccwsi = si[CCW];
    assign rif.pesi  = si[PE];
    assign rif.cwdi  = di[CW];
    assign rif.ccwdi = di[CCW];
    assign rif.pedi  = di[PE];
    assign rif.cwri  = ri[CW];
    assign rif.ccwri = ri[CCW];
    assign rif.peri  = ri[PE];

    logic        o_ro [3];
    logic        o_so [3];
    logic [63:0] o_do [3];

    assign o_ro[CW]  = rif.cwro;
    assign o_ro[CCW] = rif.ccwro;
    assign o_ro[PE]  = rif.pero;
    assign o_so[CW]  = rif.cwso;
    assign o_so[CCW] = rif.ccwso;
    assign o_so[PE]  = rif.peso;
    assign o_do[CW]  = rif.cwdo;
    assign o_do[CCW] = rif.ccwdo;
    assign o_do[PE]  = rif.pedo;

    int checks = 0;
    int errors = 0;

    // Reference model: buffer slots per port and VC, RR favour per output and VC
    bit          ib_v [3][2];
    logic [63:0] ib_d [3][2];
    bit          ob_v [3][2];
    logic [63:0] ob_d [3][2];
    bit          rr   [3][2];
    bit          pol;

    function automatic int hop_of(input logic [63:0] d);
        return int'(d[55:48]);
    endfunction

    function automatic logic [63:0] with_hop(input logic [63:0] d, input int h);
        logic [63:0] r;
        r = d;
        r[55:48] = 8'(h);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int x = 0; x < 3; x++) begin
            for (int v = 0; v < 2; v++) begin
                ib_v[x][v] = 1'b0; ib_d[x][v] = '0;
                ob_v[x][v] = 1'b0; ob_d[x][v] = '0;
                rr[x][v]   = 1'b0;
            end
        end
        pol = 1'b0;
    endtask

    task automatic compare_all();
        check("polarity", 64'(rif.polarity), 64'(pol));
        for (int x = 0; x < 3; x++) begin
            check($sformatf("ro[%0d]", x), 64'(o_ro[x]), 64'(!ib_v[x][pol]));
            check($sformatf("so[%0d]", x), 64'(o_so[x]), 64'(ob_v[x][pol]));
            check($sformatf("do[%0d]", x), o_do[x], ob_v[x][pol] ? ob_d[x][pol] : 64'h0);
        end
    endtask

    // Advances the model across one clock edge using the inputs now applied.
    task automatic model_step();
        bit          nib_v [3][2];
        logic [63:0] nib_d [3][2];
        bit          nob_v [3][2];
        logic [63:0] nob_d [3][2];
        bit          nrr   [3][2];
        int          tgt   [3];
        logic [63:0] pk    [3];
        int p, q, h, a, b, w;
        bit wa, wb;
        nib_v = ib_v; nib_d = ib_d; nob_v = ob_v; nob_d = ob_d; nrr = rr;
        p = int'(pol);
        q = 1 - p;
        for (int x = 0; x < 3; x++) begin
            if (si[x] && !ib_v[x][p]) begin
                nib_v[x][p] = 1'b1;
                nib_d[x][p] = di[x];
            end
            if (ob_v[x][p] && ri[x]) nob_v[x][p] = 1'b0;
        end
        for (int x = 0; x < 3; x++) begin
            tgt[x] = -1;
            pk[x]  = '0;
            if (ib_v[x][q]) begin
                h = hop_of(ib_d[x][q]);
                if (x == PE) begin
                    if (h == 0) nib_v[x][q] = 1'b0;
                    else begin
                        tgt[x] = ib_d[x][q][62] ? CCW : CW;
                        pk[x]  = with_hop(ib_d[x][q], h - 1);
                    end
                end else if (h == 0) begin
                    tgt[x] = PE;
                    pk[x]  = ib_d[x][q];
                end else begin
                    tgt[x] = x;
                    pk[x]  = with_hop(ib_d[x][q], h - 1);
                end
            end
        end
        for (int t = 0; t < 3; t++) begin
            if (!ob_v[t][q]) begin
                a  = (t == PE) ? CW  : t;
                b  = (t == PE) ? CCW : PE;
                wa = (tgt[a] == t);
                wb = (tgt[b] == t);
                w  = -1;
                if (wa && wb) begin
                    w = rr[t][q] ? b : a;
                    nrr[t][q] = (w == a);
                end else if (wa) w = a;
                else if (wb) w = b;
                if (w >= 0) begin
                    nob_v[t][q] = 1'b1;
                    nob_d[t][q] = pk[w];
                    nib_v[w][q] = 1'b0;
                end
            end
        end
        ib_v = nib_v; ib_d = nib_d; ob_v = nob_v; ob_d = nob_d; rr = nrr;
        pol = ~pol;
    endtask

    // Called at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic tick();
        #2;
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        for (int x = 0; x < 3; x++) begin
            si[x] = 1'b0;
            di[x] = '0;
            ri[x] = 1'b1;
        end
    endtask

    task automatic align0();
        if (pol) tick();
    endtask

    task automatic drain();
        set_idle();
        repeat (8) tick();
    endtask

    function automatic logic [63:0] rand_pkt(input bit vc, input int hop_max);
        logic [63:0] d;
        d = {$urandom, $urandom};
        d[63] = vc;
        d[55:48] = 8'($urandom_range(0, hop_max));
        return d;
    endfunction

    initial begin
        set_idle();
        reset = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_polarity", 64'(rif.polarity), 64'h0);
        for (int x = 0; x < 3; x++) begin
            check($sformatf("rst_so[%0d]", x), 64'(o_so[x]), 64'h0);
            check($sformatf("rst_ro[%0d]", x), 64'(o_ro[x]), 64'h1);
            check($sformatf("rst_do[%0d]", x), o_do[x], 64'h0);
        end
        reset = 1'b1;
        check("pol_seq0", 64'(rif.polarity), 64'h0);
        tick();
        check("pol_seq1", 64'(rif.polarity), 64'h1);
        tick();
        check("pol_seq2", 64'(rif.polarity), 64'h0);

        // PE inject: hop 2 cw becomes hop 1 on the cw output
        align0();
        si[PE] = 1'b1; di[PE] = 64'h0002_0000_1234_5678;
        tick();
        si[PE] = 1'b0;
        tick();
        check("inject_cwso", 64'(o_so[CW]), 64'h1);
        check("inject_cwdo", o_do[CW], 64'h0001_0000_1234_5678);
        check("inject_pero", 64'(o_ro[PE]), 64'h1);
        drain();

        // Eject: ccw ring packet with hop 0 goes to the PE
        align0();
        si[CCW] = 1'b1; di[CCW] = 64'h4000_0000_CAFE_F00D;
        tick();
        si[CCW] = 1'b0;
        tick();
        check("eject_peso", 64'(o_so[PE]), 64'h1);
        check("eject_pedo", o_do[PE], 64'h4000_0000_CAFE_F00D);
        drain();

        // Contention on cw output VC0: ring input first, then PE
        align0();
        si[CW] = 1'b1; di[CW] = 64'h0003_0000_0000_0001;
        si[PE] = 1'b1; di[PE] = 64'h0002_0000_0000_0002;
        tick();
        si[CW] = 1'b0; si[PE] = 1'b0;
        tick();
        check("cont_first", o_do[CW], 64'h0002_0000_0000_0001);
        tick();
        tick();
        check("cont_second", o_do[CW], 64'h0001_0000_0000_0002);
        drain();

        // Backpressure on PE output VC0
        align0();
        ri[PE] = 1'b0;
        si[CW] = 1'b1; di[CW] = 64'h0000_0000_0000_00A1;
        tick();
        si[CW] = 1'b0;
        tick();
        check("bp_first_valid", 64'(o_so[PE]), 64'h1);
        si[CW] = 1'b1; di[CW] = 64'h0000_0000_0000_00A2;
        tick();
        si[CW] = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("bp_peso_hold", 64'(o_so[PE]), 64'h1);
            check("bp_pedo_hold", o_do[PE], 64'h0000_0000_0000_00A1);
            check("bp_cwro_low", 64'(o_ro[CW]), 64'h0);
            tick();
            tick();
        end
        ri[PE] = 1'b1;
        tick();
        tick();
        check("bp_second_valid", 64'(o_so[PE]), 64'h1);
        check("bp_second_data", o_do[PE], 64'h0000_0000_0000_00A2);
        check("bp_cwro_free", 64'(o_ro[CW]), 64'h1);
        drain();

        // Reset mid-operation with input buffers loaded and outputs stalled
        align0();
        for (int x = 0; x < 3; x++) ri[x] = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int x = 0; x < 3; x++) begin
                si[x] = 1'b1;
                di[x] = rand_pkt(pol, 3);
                di[x][55:48] = 8'd5;
            end
            tick();
        end
        for (int x = 0; x < 3; x++) si[x] = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        check("mid_rst_polarity", 64'(rif.polarity), 64'h0);
        for (int x = 0; x < 3; x++) begin
            check($sformatf("mid_rst_so[%0d]", x), 64'(o_so[x]), 64'h0);
            check($sformatf("mid_rst_ro[%0d]", x), 64'(o_ro[x]), 64'h1);
        end
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
        set_idle();
        repeat (6) tick();

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int x = 0; x < 3; x++) begin
                si[x] = ($urandom_range(0, 99) < 45);
                di[x] = rand_pkt(pol, 3);
                di[x][62] = $urandom_range(0, 1) != 0;
                ri[x] = ($urandom_range(0, 99) < 70);
            end
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
